// File: rtl/conv_adder_if.sv
// Handshake and data bus of the conv2d adder array: beat input side, frame output side, status.
interface conv_adder_if #(
  parameter int unsigned BITSIZE    = 14,
  parameter int unsigned NUM_INPUTS = 27,
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned PASS_W     = 4
);
  localparam int unsigned DIN_W  = BITSIZE * NUM_INPUTS * NUM_CH;
  localparam int unsigned DOUT_W = BITSIZE * NUM_CH;

  logic              start;
  logic [PASS_W-1:0] num_passes;
  logic              in_valid;
  logic              in_ready;
  logic [DIN_W-1:0]  data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] dataout;
  logic              busy;

  modport master (
    output start, num_passes, in_valid, data_in, out_ready,
    input  in_ready, out_valid, dataout, busy
  );

  modport slave (
    input  start, num_passes, in_valid, data_in, out_ready,
    output in_ready, out_valid, dataout, busy
  );
endinterface

// File: rtl/conv_adder_array.sv
// NUM_CH pipelined signed adder trees with multi-pass accumulation and valid/ready framing.
// Define CONV_ADDER_SAT_EN to saturate dataout instead of wrapping to BITSIZE bits.
module conv_adder_array #(
  parameter int unsigned BITSIZE    = 14,
  parameter int unsigned NUM_INPUTS = 27,
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned PASS_W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  conv_adder_if.slave  bus
);
  localparam int unsigned L      = $clog2(NUM_INPUTS);
  localparam int unsigned TW     = BITSIZE + L;
  localparam int unsigned DOUT_W = BITSIZE * NUM_CH;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  // Operand count at tree level l (level 0 = raw inputs).
  function automatic int unsigned lvl_n(input int unsigned l);
    return (NUM_INPUTS + (32'd1 << l) - 32'd1) >> l;
  endfunction

`ifdef CONV_ADDER_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (BITSIZE - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  function automatic logic [BITSIZE-1:0] sat_word(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI) return SAT_HI[BITSIZE-1:0];
    if (a < SAT_LO) return SAT_LO[BITSIZE-1:0];
    return a[BITSIZE-1:0];
  endfunction
`endif

  state_t              state, state_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [PASS_W-1:0]   beats_q, beats_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [DOUT_W-1:0]   dataout_q;
  logic                start_acc;
  logic                load_out;
  logic                accept;

  logic [L-1:0]        vld;
  logic                acc_busy;
  logic signed [TW-1:0]    view [NUM_CH][L+1][NUM_INPUTS];
  logic signed [TW-1:0]    st   [NUM_CH][L][NUM_INPUTS];
  logic signed [ACC_W-1:0] acc  [NUM_CH];

  assign accept         = bus.in_valid & in_ready_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.dataout    = dataout_q;
  assign bus.busy       = busy_q;

  // Level 0 is the sign-extended input beat; level l>0 is register bank st[l-1].
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        view[c][0][i] = TW'($signed(bus.data_in[(c * NUM_INPUTS + i) * BITSIZE +: BITSIZE]));
      end
      for (int unsigned l = 0; l < L; l++) begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
          view[c][l+1][i] = st[c][l][i];
        end
      end
    end
  end

  // Pairwise reduction; an odd leftover operand is registered unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++)
        for (int unsigned l = 0; l < L; l++)
          for (int unsigned i = 0; i < NUM_INPUTS; i++)
            st[c][l][i] <= '0;
    end else begin
      vld <= L'({vld, accept});
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned l = 0; l < L; l++) begin
          for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (i < lvl_n(l + 1)) begin
              if (2 * i + 1 < lvl_n(l))
                st[c][l][i] <= view[c][l][2*i] + view[c][l][2*i+1];
              else
                st[c][l][i] <= view[c][l][2*i];
            end else begin
              st[c][l][i] <= '0;
            end
          end
        end
      end
    end
  end

  // Per-channel accumulator; acc_busy marks an add that landed this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_busy <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else begin
      acc_busy <= vld[L-1];
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (start_acc)
          acc[c] <= '0;
        else if (vld[L-1])
          acc[c] <= acc[c] + ACC_W'(view[c][L][0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d     = state;
    pass_d      = pass_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q;
    start_acc   = 1'b0;
    load_out    = 1'b0;
    in_ready_d  = 1'b0;
    busy_d      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d   = ACCUM;
          pass_d    = (bus.num_passes == '0) ? PASS_W'(1) : bus.num_passes;
          beats_d   = '0;
          start_acc = 1'b1;
        end
      end
      ACCUM: begin
        if (accept) begin
          beats_d = beats_q + PASS_W'(1);
          if (beats_d == pass_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (vld == '0 && !acc_busy) begin
          state_d     = HOLD;
          load_out    = 1'b1;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pass_q      <= '0;
      beats_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dataout_q   <= '0;
    end else begin
      pass_q      <= pass_d;
      beats_q     <= beats_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      if (load_out) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
`ifdef CONV_ADDER_SAT_EN
          dataout_q[c*BITSIZE +: BITSIZE] <= sat_word(acc[c]);
`else
          dataout_q[c*BITSIZE +: BITSIZE] <= acc[c][BITSIZE-1:0];
`endif
        end
      end
    end
  end
endmodule
